button_event_queue: RTL
=======================

# button_event_queue

Turns the one-cycle button pulses coming out of the per-button debounce and one-pulse stages into an ordered stream of 3-bit event codes for the game control logic. Simultaneous pulses are never lost. They are held in a pending mask, serialised lowest-index-first, and buffered in a small FIFO behind a valid/ready handshake. The block sits directly downstream of the one-pulse stage and upstream of the game FSMs.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- btn_pulse  in  8  one-cycle pulses, bit i = button i; any combination may be high in one cycle
- evt_ready  in  1  consumer accepts the head event this cycle
- evt_valid  out  1  FIFO non-empty
- evt_code  out  3  button index at FIFO head; 0 when empty
- pending  out  8  latched events not yet pushed into the FIFO
- count  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- drop_cnt  out  8  saturating count of cycles in which at least one pulse merged into an already-pending bit

## Operation
- Reset (async assert, takes effect immediately): pending=0, count=0, read and write pointers=0, drop_cnt=0, evt_valid=0, evt_code=0. FIFO storage contents are don't-care.
- pop = evt_valid & evt_ready.
- can_push = (count < DEPTH) | pop.
- sel = index of the lowest set bit of pending. It is valid when pending != 0.
- push = can_push & (pending != 0). On push: mem[wr_ptr] <= sel, wr_ptr++, and clear_mask = one-hot(sel). Otherwise clear_mask = 0.
- pending_next = (pending & ~clear_mask) | btn_pulse.
  - A pulse on the bit being cleared in the same cycle leaves that bit set. It is a new event, not a drop.
- drop condition: |(btn_pulse & pending & ~clear_mask). The event merges into the existing pending bit.
  - On a drop cycle, drop_cnt increments by exactly 1 regardless of how many bits merged.
  - drop_cnt saturates at 255.
- On pop: rd_ptr++.
- count_next = count + push - pop.
- Pointers wrap modulo DEPTH with no special case.
- Push and pop may occur in the same cycle at any occupancy, including full (count=DEPTH with pop) and count=1. In that case count is unchanged.
- evt_code = mem[rd_ptr] when count != 0, else 0. It is a combinational read of registered storage.
- evt_valid = (count != 0).
- At most one push per cycle. Events leave the FIFO in push order.
- There is no state machine beyond pending, the FIFO, and the counter. The block never blocks btn_pulse; its only loss mechanism is merging, which drop_cnt counts.

## Timing
- Cycle n = period after posedge n.
- Pulse high in cycle 0 → pending bit set in cycle 1 → pushed at edge 2 if FIFO has room and no lower bit is pending → evt_valid/evt_code in cycle 2. Minimum latency is 2 cycles.
- With k bits pending and FIFO space, they drain one per cycle, lowest index first, in k cycles.
- Holding evt_ready=1 allows one pop per cycle. Sustained throughput is 1 event per cycle.
- evt_code and evt_valid are stable while evt_ready=0 and rst=0. Arriving pulses never change the head.
- Reset mid-operation discards all pending and queued events. In the first cycle after deassertion, evt_valid=0.
- A pulse coincident with the rst deassertion edge is not captured. The first capture happens on the next edge.

## Test plan
- Single event: btn_pulse=0x08 for one cycle, evt_ready=1 → evt_valid=1 with evt_code=3 exactly 2 cycles later for 1 cycle; count returns to 0; drop_cnt=0.
- Simultaneous pulses: btn_pulse=0x81 in one cycle, evt_ready=1 → codes 0 then 7 on consecutive cycles; pending goes 0x81→0x80→0x00.
- Backpressure fill (DEPTH=4): evt_ready=0, pulse 0xFF once → after 6 cycles count=4, head code=0, pending=0xF0. Then raise evt_ready → codes 0..7 in order over 8 consecutive cycles; count never exceeds 4.
- Full with concurrent pop/push: count=4, pending=0x20, evt_ready=1 for one cycle → code popped, 5 pushed in the same cycle, count stays 4, pending=0x00.
- Drop accounting: evt_ready=0, FIFO full, pulse 0x04 in two separate cycles → pending=0x04, drop_cnt=1. Pulse 0x06 while pending=0x06 → drop_cnt=2, not 3. After 300 such drop cycles, drop_cnt=255.
- Async reset mid-stream: count=3, pending=0x11, assert rst between clock edges → all outputs 0 immediately. After release with btn_pulse=0, evt_valid stays 0.

Source files
------------

// File: rtl/button_event_queue.sv
// button_event_queue: serialises one-cycle button pulses into an ordered stream
//   of 3-bit event codes (button index), lowest pending index first.
// Latency: pulse in cycle n -> pending in cycle n+1 -> head of FIFO in cycle n+2.
// Backpressure: evt_ready low lets the FIFO fill, then events wait in pending.
//   btn_pulse is never blocked; repeat pulses on a pending bit merge (drop_cnt).
//
// Ports:
//   clk        system clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   btn_pulse  one-cycle pulses, bit i = button i, any combination per cycle
//   evt_ready  consumer takes the head event this cycle
//   evt_valid  FIFO non-empty
//   evt_code   button index at FIFO head, 0 when empty
//   pending    latched events not yet pushed into the FIFO
//   count      FIFO occupancy, 0..DEPTH
//   drop_cnt   saturating count of cycles where a pulse merged into a pending bit

module button_event_queue #(
  parameter int DEPTH = 4  // power of two, 2..16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               btn_pulse,
  input  logic                     evt_ready,
  output logic                     evt_valid,
  output logic [2:0]               evt_code,
  output logic [7:0]               pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // FIFO storage and pointers; pointers wrap naturally since DEPTH is 2^AW.
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic          pop;
  logic          push;
  logic          can_push;
  logic          full;
  logic [2:0]    sel;
  logic [7:0]    clear_mask;
  logic          drop;

  // Head of FIFO is a combinational read of registered storage.
  assign evt_valid = (count != '0);
  assign evt_code  = evt_valid ? mem[rd_ptr] : 3'd0;

  assign pop      = evt_valid & evt_ready;
  assign full     = (count == CW'(DEPTH));
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign can_push = ~full | pop;
  assign push     = can_push & (pending != 8'd0);

  // Lowest set bit of pending; scanning downward lets the lowest index win.
  always_comb begin
    sel = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) sel = 3'(i);
    end
  end

  assign clear_mask = push ? (8'd1 << sel) : 8'd0;

  // A pulse on the bit being pushed this cycle is a fresh event, not a merge,
  // which is why the cleared bit is excluded here.
  assign drop = |(btn_pulse & pending & ~clear_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 8'd0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= 8'd0;
    end else begin
      pending <= (pending & ~clear_mask) | btn_pulse;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      // One increment per drop cycle, however many bits merged.
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage needs no reset; entries are only visible once counted in.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sel;
  end

endmodule
